// File: rtl/id_ex_register.sv
// ---------------------------------------------------------------------------
// id_ex_register
//
// ID/EX pipeline register of the 5-stage RISC-V core, between decode and
// execute. Every field is captured on the rising edge of clk_i, and all
// outputs come straight from flops.
//
// Per-edge update rule, highest priority first:
//   Flush_i           -> load a bubble (squash the stage)
//   Hold_i            -> keep every pipeline field unchanged
//   NoOp_i            -> load a bubble (load-use stall from the hazard unit)
//   otherwise         -> load the decode fields and set Valid_o
//
// A bubble is all-zero: no control asserted, RdAddr_o = x0, Valid_o = 0.
// Because of that it never causes a write and never produces a meaningful
// forwarding or load-use match downstream.
//
// Optional build macro: ID_EX_STATS_EN
//   defined   : BubbleCnt_o counts NoOp bubbles, FlushCnt_o counts flushes.
//               Both saturate at all-ones and are cleared only by reset.
//   undefined : no counter flops exist; both outputs are tied to 0.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   *_i decode fields            control, ALUOp, operands, Imm, funct, addrs
//   NoOp_i, Flush_i, Hold_i      bubble insert, squash, freeze
//   *_o registered fields        same set as the inputs
//   Valid_o                      stage holds a real instruction
//   BubbleCnt_o, FlushCnt_o      statistics counters (width CNT_W)
// ---------------------------------------------------------------------------
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [9:0]        funct_i,
    input  logic [4:0]        RS1addr_i,
    input  logic [4:0]        RS2addr_i,
    input  logic [4:0]        RdAddr_i,

    input  logic              NoOp_i,
    input  logic              Flush_i,
    input  logic              Hold_i,

    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [9:0]        funct_o,
    output logic [4:0]        RS1addr_o,
    output logic [4:0]        RS2addr_o,
    output logic [4:0]        RdAddr_o,
    output logic              Valid_o,
    output logic [CNT_W-1:0]  BubbleCnt_o,
    output logic [CNT_W-1:0]  FlushCnt_o
);

    // Handshake note: there is no valid/ready pair here. The stage advances
    // on every edge unless Hold_i freezes it; Flush_i overrides Hold_i.

    logic load_en;      // the pipeline fields change on this edge
    logic load_bubble;  // ...and what gets loaded is a bubble
    logic noop_bubble;  // bubble caused by NoOp_i alone (counted)

    always_comb begin
        load_en     = Flush_i | ~Hold_i;
        load_bubble = Flush_i | (~Hold_i & NoOp_i);
        noop_bubble = ~Flush_i & ~Hold_i & NoOp_i;
    end

    // -----------------------------------------------------------------------
    // Pipeline fields
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            ALUSrc_o   <= 1'b0;
            ALUOp_o    <= '0;
            RS1data_o  <= '0;
            RS2data_o  <= '0;
            Imm_o      <= '0;
            funct_o    <= '0;
            RS1addr_o  <= '0;
            RS2addr_o  <= '0;
            RdAddr_o   <= '0;
            Valid_o    <= 1'b0;
        end else if (load_en) begin
            if (load_bubble) begin
                RegWrite_o <= 1'b0;
                MemtoReg_o <= 1'b0;
                MemRead_o  <= 1'b0;
                MemWrite_o <= 1'b0;
                ALUSrc_o   <= 1'b0;
                ALUOp_o    <= '0;
                RS1data_o  <= '0;
                RS2data_o  <= '0;
                Imm_o      <= '0;
                funct_o    <= '0;
                RS1addr_o  <= '0;
                RS2addr_o  <= '0;
                RdAddr_o   <= '0;
                Valid_o    <= 1'b0;
            end else begin
                RegWrite_o <= RegWrite_i;
                MemtoReg_o <= MemtoReg_i;
                MemRead_o  <= MemRead_i;
                MemWrite_o <= MemWrite_i;
                ALUSrc_o   <= ALUSrc_i;
                ALUOp_o    <= ALUOp_i;
                RS1data_o  <= RS1data_i;
                RS2data_o  <= RS2data_i;
                Imm_o      <= Imm_i;
                funct_o    <= funct_i;
                RS1addr_o  <= RS1addr_i;
                RS2addr_o  <= RS2addr_i;
                RdAddr_o   <= RdAddr_i;
                Valid_o    <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Statistics counters
    // -----------------------------------------------------------------------
`ifdef ID_EX_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating: once all-ones, the counter sticks until reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (Flush_i && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
            if (noop_bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

    assign BubbleCnt_o = bubble_cnt;
    assign FlushCnt_o  = flush_cnt;
`else
    logic unused_stats;
    assign unused_stats = noop_bubble;
    assign BubbleCnt_o  = '0;
    assign FlushCnt_o   = '0;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// ---------------------------------------------------------------------------
// tb_id_ex_register
//
// Directed, table-driven bench for id_ex_register (CNT_W = 2 so counter
// saturation is reachable quickly). The vector table is applied in order;
// state carries from one row to the next. Counter expectations apply when
// ID_EX_STATS_EN is defined and collapse to 0 otherwise.
// ---------------------------------------------------------------------------
module tb_id_ex_register;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;
`ifdef ID_EX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i;
    logic [1:0]        alu_op_i;
    logic [DATA_W-1:0] rs1_data_i, rs2_data_i, imm_i;
    logic [9:0]        funct_i;
    logic [4:0]        rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic              noop_i, flush_i, hold_i;

    logic              reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o;
    logic [1:0]        alu_op_o;
    logic [DATA_W-1:0] rs1_data_o, rs2_data_o, imm_o;
    logic [9:0]        funct_o;
    logic [4:0]        rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic              valid_o;
    logic [CNT_W-1:0]  bubble_cnt_o, flush_cnt_o;

    id_ex_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .RegWrite_i  (reg_write_i),
        .MemtoReg_i  (mem_to_reg_i),
        .MemRead_i   (mem_read_i),
        .MemWrite_i  (mem_write_i),
        .ALUSrc_i    (alu_src_i),
        .ALUOp_i     (alu_op_i),
        .RS1data_i   (rs1_data_i),
        .RS2data_i   (rs2_data_i),
        .Imm_i       (imm_i),
        .funct_i     (funct_i),
        .RS1addr_i   (rs1_addr_i),
        .RS2addr_i   (rs2_addr_i),
        .RdAddr_i    (rd_addr_i),
        .NoOp_i      (noop_i),
        .Flush_i     (flush_i),
        .Hold_i      (hold_i),
        .RegWrite_o  (reg_write_o),
        .MemtoReg_o  (mem_to_reg_o),
        .MemRead_o   (mem_read_o),
        .MemWrite_o  (mem_write_o),
        .ALUSrc_o    (alu_src_o),
        .ALUOp_o     (alu_op_o),
        .RS1data_o   (rs1_data_o),
        .RS2data_o   (rs2_data_o),
        .Imm_o       (imm_o),
        .funct_o     (funct_o),
        .RS1addr_o   (rs1_addr_o),
        .RS2addr_o   (rs2_addr_o),
        .RdAddr_o    (rd_addr_o),
        .Valid_o     (valid_o),
        .BubbleCnt_o (bubble_cnt_o),
        .FlushCnt_o  (flush_cnt_o)
    );

    // ---------------- payload / vector records ----------------
    // ctrl = {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc}
    typedef struct packed {
        logic [4:0]  ctrl;
        logic [1:0]  alu_op;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
    } pl_t;

    typedef struct {
        pl_t  in;
        logic noop, flush, hold;
        pl_t  exp;
        logic exp_valid;
        int   exp_bcnt;
        int   exp_fcnt;
    } vec_t;

    localparam pl_t BUB = '0;
    localparam pl_t PA  = '{5'b10100, 2'b00, 32'h0000_1234, 32'h0000_0055, 32'hFFFF_FFF0, 10'h000, 5'd2,  5'd3,  5'd5};
    localparam pl_t PB  = '{5'b10001, 2'b10, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0000_0004, 10'h207, 5'd5,  5'd6,  5'd8};
    localparam pl_t PC  = '{5'b11111, 2'b11, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h7FFF_FFFF, 10'h3FF, 5'd31, 5'd30, 5'd7};
    localparam pl_t PD  = '{5'b01010, 2'b01, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 10'h155, 5'd9,  5'd10, 5'd11};
    localparam pl_t PE  = '{5'b00110, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 10'h2AA, 5'd1,  5'd4,  5'd20};

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input pl_t p, input logic noop, input logic flush, input logic hold);
        {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i} = p.ctrl;
        alu_op_i   = p.alu_op;
        rs1_data_i = p.rs1_data;
        rs2_data_i = p.rs2_data;
        imm_i      = p.imm;
        funct_i    = p.funct;
        rs1_addr_i = p.rs1_addr;
        rs2_addr_i = p.rs2_addr;
        rd_addr_i  = p.rd_addr;
        noop_i     = noop;
        flush_i    = flush;
        hold_i     = hold;
    endtask

    task automatic check_all(input string tag, input pl_t e, input logic ev, input int eb, input int ef);
        logic [4:0] act_ctrl;
        act_ctrl = {reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o};
        chk({tag, ".ctrl"},  {27'd0, act_ctrl},   {27'd0, e.ctrl});
        chk({tag, ".aluop"}, {30'd0, alu_op_o},   {30'd0, e.alu_op});
        chk({tag, ".rs1d"},  rs1_data_o,          e.rs1_data);
        chk({tag, ".rs2d"},  rs2_data_o,          e.rs2_data);
        chk({tag, ".imm"},   imm_o,               e.imm);
        chk({tag, ".funct"}, {22'd0, funct_o},    {22'd0, e.funct});
        chk({tag, ".rs1a"},  {27'd0, rs1_addr_o}, {27'd0, e.rs1_addr});
        chk({tag, ".rs2a"},  {27'd0, rs2_addr_o}, {27'd0, e.rs2_addr});
        chk({tag, ".rd"},    {27'd0, rd_addr_o},  {27'd0, e.rd_addr});
        chk({tag, ".valid"}, {31'd0, valid_o},    {31'd0, ev});
        chk({tag, ".bcnt"},  {30'd0, bubble_cnt_o}, STATS ? eb : 0);
        chk({tag, ".fcnt"},  {30'd0, flush_cnt_o},  STATS ? ef : 0);
    endtask

    // ---------------- vector table ----------------
    vec_t vt[$];

    task automatic add(input pl_t in, input logic noop, input logic flush, input logic hold,
                       input pl_t exp, input logic ev, input int eb, input int ef);
        vec_t v;
        v.in = in; v.noop = noop; v.flush = flush; v.hold = hold;
        v.exp = exp; v.exp_valid = ev; v.exp_bcnt = eb; v.exp_fcnt = ef;
        vt.push_back(v);
    endtask

    initial begin
        //   input noop flush hold   expected valid bcnt fcnt
        add(PA, 0, 0, 0,   PA,  1, 0, 0);  // normal load (lw x5)
        add(PB, 1, 0, 0,   BUB, 0, 1, 0);  // load-use bubble
        add(PB, 0, 0, 0,   PB,  1, 1, 0);  // stalled instruction now loads
        add(PC, 0, 0, 0,   PC,  1, 1, 0);  // load rd=7
        add(PD, 0, 0, 1,   PC,  1, 1, 0);  // hold 1
        add(PE, 1, 0, 1,   PC,  1, 1, 0);  // hold 2 with NoOp: ignored, no count
        add(PD, 0, 0, 1,   PC,  1, 1, 0);  // hold 3
        add(PD, 0, 1, 1,   BUB, 0, 1, 1);  // flush beats hold
        add(PD, 0, 0, 0,   PD,  1, 1, 1);  // load
        add(PE, 1, 1, 0,   BUB, 0, 1, 2);  // flush beats NoOp, only flush counts
        add(PE, 1, 0, 0,   BUB, 0, 2, 2);  // five NoOp bubbles: 2,3,3,3,3
        add(PE, 1, 0, 0,   BUB, 0, 3, 2);
        add(PE, 1, 0, 0,   BUB, 0, 3, 2);
        add(PE, 1, 0, 0,   BUB, 0, 3, 2);
        add(PE, 1, 0, 0,   BUB, 0, 3, 2);
        add(PE, 0, 1, 0,   BUB, 0, 3, 3);  // flush count to saturation
        add(PE, 0, 1, 0,   BUB, 0, 3, 3);  // stays saturated
        add(PA, 0, 0, 0,   PA,  1, 3, 3);  // load after saturation

        // ---- reset with nonzero inputs ----
        drive(PC, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", BUB, 1'b0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // ---- table ----
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].in, vt[i].noop, vt[i].flush, vt[i].hold);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vt[i].exp, vt[i].exp_valid,
                      vt[i].exp_bcnt, vt[i].exp_fcnt);
        end

        // ---- no combinational path: change inputs between edges ----
        @(negedge clk);
        drive(PD, 1'b1, 1'b1, 1'b0);
        #2;
        check_all("nocomb", PA, 1'b1, 3, 3);

        // ---- asynchronous reset between edges, then normal load ----
        drive(PC, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_all("async_rst", BUB, 1'b0, 0, 0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst_load", PC, 1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
